// File: rtl/pc_addr_seq.sv
// Registered PC/address sequencer: instruction fetch and data access over a req/ack
// handshake, with call/return stack and sticky error. Optional macro: ALIGN_CHECK_EN.
module pc_addr_seq #(
  parameter  int MEM_DEPTH   = 4096,
  parameter  int WORD_BYTES  = 2,
  parameter  int STACK_DEPTH = 8,
  localparam int ADDR_WIDTH  = $clog2(MEM_DEPTH * WORD_BYTES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [2:0]            i_mode,
  input  logic [31:0]           i_alu_addr,
  output logic                  o_ready,
  output logic                  o_req,
  input  logic                  i_mem_ack,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_data_sel,
  output logic [31:0]           o_pc,
  output logic                  o_err
);

  localparam int          SPW  = $clog2(STACK_DEPTH + 1);
  localparam int          IDXW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [31:0] STEP = 32'(WORD_BYTES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_DATA
  } state_t;

  typedef enum logic [2:0] {
    M_NEXT,
    M_JUMP,
    M_RET,
    M_DATA,
    M_CALL
  } mode_t;

  state_t          state_q;
  logic [31:0]     pc_q;
  logic [SPW-1:0]  sp_q;
  logic            err_q;
  logic [31:0]     stack_q [STACK_DEPTH];

  logic [31:0]     pc_inc;
  logic [31:0]     next_pc;
  logic [31:0]     top_val;
  logic [SPW-1:0]  sp_dec;
  logic [IDXW-1:0] push_idx;
  logic [IDXW-1:0] top_idx;
  logic            stack_full;
  logic            stack_empty;
  logic            addr_bad;
  logic            cmd_accept;
  logic            push_en;
  mode_t           mode_raw;
  mode_t           mode_eff;

  assign pc_inc      = pc_q + STEP;
  assign sp_dec      = sp_q - SPW'(1);
  assign push_idx    = sp_q[IDXW-1:0];
  assign top_idx     = sp_dec[IDXW-1:0];
  assign top_val     = stack_q[top_idx];
  assign stack_full  = (sp_q == SPW'(STACK_DEPTH));
  assign stack_empty = (sp_q == '0);
  assign cmd_accept  = (state_q == S_DECODE) && i_valid;

  always_comb begin
    mode_raw = M_NEXT;
    case (i_mode)
      3'd1:    mode_raw = M_JUMP;
      3'd2:    mode_raw = M_RET;
      3'd3:    mode_raw = M_DATA;
      3'd4:    mode_raw = M_CALL;
      default: mode_raw = M_NEXT;
    endcase
  end

  // A misaligned target demotes the command to a plain sequential step.
  always_comb begin
    addr_bad = 1'b0;
    mode_eff = mode_raw;
`ifdef ALIGN_CHECK_EN
    if ((mode_raw == M_JUMP || mode_raw == M_DATA || mode_raw == M_CALL) &&
        ((i_alu_addr & (STEP - 32'd1)) != 32'd0)) begin
      addr_bad = 1'b1;
      mode_eff = M_NEXT;
    end
`endif
  end

  always_comb begin
    next_pc = pc_inc;
    case (mode_eff)
      M_JUMP,
      M_CALL:  next_pc = i_alu_addr;
      M_RET:   next_pc = stack_empty ? pc_inc : top_val;
      M_DATA:  next_pc = pc_q;
      default: next_pc = pc_inc;
    endcase
  end

  assign push_en = cmd_accept && (mode_eff == M_CALL) && !stack_full;

  // Stack storage needs no reset: entries are only read below the pointer.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_q[push_idx] <= pc_inc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      sp_q       <= '0;
      err_q      <= 1'b0;
      o_ready    <= 1'b0;
      o_req      <= 1'b0;
      o_addr     <= '0;
      o_data_sel <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q    <= S_FETCH;
          o_req      <= 1'b1;
          o_addr     <= pc_q[ADDR_WIDTH-1:0];
          o_data_sel <= 1'b0;
        end

        S_FETCH: begin
          if (i_mem_ack) begin
            state_q <= S_DECODE;
            o_req   <= 1'b0;
            o_ready <= 1'b1;
          end
        end

        S_DECODE: begin
          if (i_valid) begin
            o_ready <= 1'b0;
            o_req   <= 1'b1;
            if (addr_bad) begin
              err_q <= 1'b1;
            end
            if (mode_eff == M_DATA) begin
              state_q    <= S_DATA;
              o_addr     <= i_alu_addr[ADDR_WIDTH-1:0];
              o_data_sel <= 1'b1;
            end else begin
              state_q    <= S_FETCH;
              pc_q       <= next_pc;
              o_addr     <= next_pc[ADDR_WIDTH-1:0];
              o_data_sel <= 1'b0;
            end
            if (mode_eff == M_CALL) begin
              if (stack_full) begin
                err_q <= 1'b1;
              end else begin
                sp_q <= sp_q + SPW'(1);
              end
            end
            if (mode_eff == M_RET) begin
              if (stack_empty) begin
                err_q <= 1'b1;
              end else begin
                sp_q <= sp_dec;
              end
            end
          end
        end

        S_DATA: begin
          if (i_mem_ack) begin
            state_q    <= S_FETCH;
            pc_q       <= pc_inc;
            o_addr     <= pc_inc[ADDR_WIDTH-1:0];
            o_data_sel <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          o_req   <= 1'b0;
          o_ready <= 1'b0;
        end
      endcase
    end
  end

  assign o_pc  = pc_q;
  assign o_err = err_q;

  a_ready_req_excl: assert property (@(posedge clk) disable iff (!rst) !(o_ready && o_req));
  a_sp_bound:       assert property (@(posedge clk) disable iff (!rst) sp_q <= SPW'(STACK_DEPTH));

endmodule

// File: tb/tb_pc_addr_seq.sv
// Directed bench for pc_addr_seq: command table plus hand-written stall, stack,
// data-access and mid-transaction reset sequences.
module tb_pc_addr_seq;

  localparam int AW = 13;

`ifdef ALIGN_CHECK_EN
  localparam logic ALIGN_ON = 1'b1;
`else
  localparam logic ALIGN_ON = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          i_valid;
  logic [2:0]    i_mode;
  logic [31:0]   i_alu_addr;
  logic          o_ready;
  logic          o_req;
  logic          i_mem_ack;
  logic [AW-1:0] o_addr;
  logic          o_data_sel;
  logic [31:0]   o_pc;
  logic          o_err;

  int n_checks = 0;
  int n_fail   = 0;

  pc_addr_seq #(.MEM_DEPTH(4096), .WORD_BYTES(2), .STACK_DEPTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_mode     (i_mode),
    .i_alu_addr (i_alu_addr),
    .o_ready    (o_ready),
    .o_req      (o_req),
    .i_mem_ack  (i_mem_ack),
    .o_addr     (o_addr),
    .o_data_sel (o_data_sel),
    .o_pc       (o_pc),
    .o_err      (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    mode;
    logic [31:0]   addr;
    int            delay;
    logic [31:0]   exp_pc;
    logic [AW-1:0] exp_addr;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Waits for a request, checks it, optionally stalls it while poking i_valid, then acks.
  task automatic service(input string nm, input logic [AW-1:0] ea, input logic es, input int delay);
    int n = 0;
    while (o_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_req"}, 32'(o_req), 32'd1);
    check({nm, "_addr"}, 32'(o_addr), 32'(ea));
    check({nm, "_sel"}, 32'(o_data_sel), 32'(es));
    for (int d = 0; d < delay; d++) begin
      i_valid    = 1'b1;
      i_mode     = 3'd1;
      i_alu_addr = 32'h0000_0100;
      @(negedge clk);
      check({nm, "_stall_req"}, 32'(o_req), 32'd1);
      check({nm, "_stall_addr"}, 32'(o_addr), 32'(ea));
      check({nm, "_stall_rdy"}, 32'(o_ready), 32'd0);
    end
    i_valid   = 1'b0;
    i_mem_ack = 1'b1;
    @(negedge clk);
    i_mem_ack = 1'b0;
    if (es == 1'b0) begin
      check({nm, "_post_rdy"}, 32'(o_ready), 32'd1);
      check({nm, "_post_req"}, 32'(o_req), 32'd0);
    end
  endtask

  task automatic issue(input string nm, input logic [2:0] m, input logic [31:0] a);
    int n = 0;
    while (o_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_ready"}, 32'(o_ready), 32'd1);
    i_valid    = 1'b1;
    i_mode     = m;
    i_alu_addr = a;
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  initial begin
    logic        base_err;
    logic [31:0] push_val;

    tbl[0]  = '{3'd0, 32'h0,         0, 32'h2,         13'h2};
    tbl[1]  = '{3'd0, 32'h0,         3, 32'h4,         13'h4};
    tbl[2]  = '{3'd0, 32'h0,         0, 32'h6,         13'h6};
    tbl[3]  = '{3'd1, 32'hA,         0, 32'hA,         13'hA};
    tbl[4]  = '{3'd4, 32'h14,        0, 32'h14,        13'h14};
    tbl[5]  = '{3'd2, 32'h0,         0, 32'hC,         13'hC};
    tbl[6]  = '{3'd7, 32'h500,       0, 32'hE,         13'hE};
    tbl[7]  = '{3'd1, 32'h8,         1, 32'h8,         13'h8};
    tbl[8]  = '{3'd1, 32'hFFFF_FFFE, 0, 32'hFFFF_FFFE, 13'h1FFE};
    tbl[9]  = '{3'd0, 32'h0,         0, 32'h0,         13'h0};
    tbl[10] = '{3'd1, 32'h4006,      0, 32'h4006,      13'h6};
    tbl[11] = '{3'd1, 32'h8,         0, 32'h8,         13'h8};

    rst        = 1'b1;
    i_valid    = 1'b0;
    i_mode     = 3'd0;
    i_alu_addr = 32'h0;
    i_mem_ack  = 1'b0;
    #3 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req",   32'(o_req),      32'd0);
    check("rst_ready", 32'(o_ready),    32'd0);
    check("rst_addr",  32'(o_addr),     32'd0);
    check("rst_sel",   32'(o_data_sel), 32'd0);
    check("rst_pc",    o_pc,            32'd0);
    check("rst_err",   32'(o_err),      32'd0);

    rst = 1'b1;
    @(negedge clk);
    check("first_req",  32'(o_req),  32'd1);
    check("first_addr", 32'(o_addr), 32'd0);
    service("fetch0", 13'h0, 1'b0, 0);

    for (int i = 0; i < 12; i++) begin
      issue($sformatf("tbl%0d", i), tbl[i].mode, tbl[i].addr);
      check($sformatf("tbl%0d_pc", i), o_pc, tbl[i].exp_pc);
      check($sformatf("tbl%0d_err", i), 32'(o_err), 32'd0);
      service($sformatf("tbl%0d_f", i), tbl[i].exp_addr, 1'b0, tbl[i].delay);
    end

    // Data access from pc=8 at a misaligned, out-of-range address.
    issue("data", 3'd3, 32'h0000_2005);
    if (ALIGN_ON) begin
      check("data_pc",  o_pc,        32'hA);
      check("data_err", 32'(o_err),  32'd1);
      service("data_next", 13'hA, 1'b0, 0);
    end else begin
      check("data_pc",  o_pc,        32'h8);
      service("data_req", 13'h5, 1'b1, 1);
      check("data_pc_after", o_pc,   32'hA);
      check("data_err", 32'(o_err),  32'd0);
      service("data_next", 13'hA, 1'b0, 0);
    end
    base_err = ALIGN_ON;

    for (int k = 1; k <= 9; k++) begin
      issue($sformatf("call%0d", k), 3'd4, 32'(k) * 32'h100);
      check($sformatf("call%0d_pc", k), o_pc, 32'(k) * 32'h100);
      check($sformatf("call%0d_err", k), 32'(o_err), 32'(base_err || (k == 9)));
      service($sformatf("call%0d_f", k), 13'(k * 256), 1'b0, 0);
    end
    for (int j = 1; j <= 8; j++) begin
      int c;
      c = 9 - j;
      push_val = (c == 1) ? 32'hC : (32'(c - 1) * 32'h100 + 32'd2);
      issue($sformatf("ret%0d", j), 3'd2, 32'h0);
      check($sformatf("ret%0d_pc", j), o_pc, push_val);
      check($sformatf("ret%0d_err", j), 32'(o_err), 32'd1);
      service($sformatf("ret%0d_f", j), push_val[AW-1:0], 1'b0, 0);
    end
    issue("ret_under", 3'd2, 32'h0);
    check("ret_under_pc",  o_pc,       32'hE);
    check("ret_under_err", 32'(o_err), 32'd1);
    service("ret_under_f", 13'hE, 1'b0, 0);
    issue("after_err", 3'd0, 32'h0);
    check("after_err_pc",  o_pc,       32'h10);
    check("sticky_err",    32'(o_err), 32'd1);
    service("after_err_f", 13'h10, 1'b0, 0);

    // Reset while a data request is outstanding.
    issue("rdata", 3'd3, 32'h0000_0040);
    check("rdata_req",  32'(o_req),      32'd1);
    check("rdata_addr", 32'(o_addr),     32'h40);
    check("rdata_sel",  32'(o_data_sel), 32'd1);
    i_mem_ack = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("mid_rst_req",  32'(o_req),      32'd0);
    check("mid_rst_pc",   o_pc,            32'd0);
    check("mid_rst_addr", 32'(o_addr),     32'd0);
    check("mid_rst_sel",  32'(o_data_sel), 32'd0);
    check("mid_rst_err",  32'(o_err),      32'd0);
    @(negedge clk);
    i_mem_ack = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rerun_pc", o_pc, 32'd0);
    service("rerun_f", 13'h0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
